// File: rtl/gps_sample_capture.sv
// Raw I/Q sample snapshot engine: converts ADC samples to two's complement, packs them
// into words over a programmed capture window and buffers them in a first-word fall-through FIFO.
module gps_sample_capture #(
    parameter int SAMPLE_W = 2,
    parameter int WORD_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                     mclk,
    input  logic                     mclr,
    input  logic [SAMPLE_W-1:0]      adc_i,
    input  logic [SAMPLE_W-1:0]      adc_q,
    input  logic                     fmt_sel,
    input  logic                     q_en,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         cap_len,
    input  logic                     rd_en,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NSLOT  = WORD_W / SAMPLE_W;
    localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    localparam logic [SLOT_W-1:0]   LAST_IQ  = SLOT_W'(NSLOT / 2 - 1);
    localparam logic [SLOT_W-1:0]   LAST_I   = SLOT_W'(NSLOT - 1);
    localparam logic [SLOT_W-1:0]   SLOT_ONE = SLOT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]         PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]         FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [SAMPLE_W-1:0] MSB_MASK = SAMPLE_W'(1) << (SAMPLE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    function automatic logic signed [SAMPLE_W-1:0] to_twos(input logic [SAMPLE_W-1:0] x,
                                                           input logic offset_bin);
        return signed'(offset_bin ? (x ^ MSB_MASK) : x);
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        len_q;
    logic                    q_en_q;
    logic                    fmt_q;
    logic [SLOT_W-1:0]       slot_cnt_q;
    logic [CNT_W-1:0]        word_cnt_q;
    logic                    overflow_q;
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [WORD_W-1:0]       pack_p1;
    logic [WORD_W-1:0]       mem [DEPTH];

    logic signed [SAMPLE_W-1:0] i_p0, q_p0;
    logic [WORD_W-1:0]       pack_nxt;
    logic                    last_slot;
    logic                    push_req, push_ok, pop;
    logic                    arm_go;
    logic [AW:0]             level_int;
    logic                    empty, full;

    // Stage 0: format conversion and slot packing for the current sample
    assign i_p0      = to_twos(adc_i, fmt_q);
    assign q_p0      = to_twos(adc_q, fmt_q);
    assign last_slot = (slot_cnt_q == (q_en_q ? LAST_IQ : LAST_I));
    assign pack_nxt  = q_en_q
        ? ((pack_p1 >> (2 * SAMPLE_W)) | (WORD_W'({q_p0, i_p0}) << (WORD_W - 2 * SAMPLE_W)))
        : ((pack_p1 >> SAMPLE_W)       | (WORD_W'($unsigned(i_p0)) << (WORD_W - SAMPLE_W)));

    assign level_int = wr_ptr_q - rd_ptr_q;
    assign empty     = (level_int == '0);
    assign full      = (level_int == FULL_LVL);
    assign pop       = rd_en && !empty;
    assign push_req  = (state_q == S_CAPTURE) && !abort && last_slot;
    assign push_ok   = push_req && (!full || pop);
    assign arm_go    = arm && !abort && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (arm) state_d = S_ARMED;
                S_ARMED:        if (trig) state_d = (len_q == '0) ? S_DONE : S_CAPTURE;
                S_CAPTURE:      if (push_req && (word_cnt_q + CNT_ONE == len_q)) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge mclr) begin
        if (!mclr) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            q_en_q     <= 1'b0;
            fmt_q      <= 1'b0;
            slot_cnt_q <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (arm_go) begin
                len_q      <= cap_len;
                q_en_q     <= q_en;
                fmt_q      <= fmt_sel;
                overflow_q <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (state_q == S_CAPTURE && !abort)
                slot_cnt_q <= last_slot ? '0 : slot_cnt_q + SLOT_ONE;
            else
                slot_cnt_q <= '0;
            if (state_q == S_ARMED)
                word_cnt_q <= '0;
            else if (push_req)
                word_cnt_q <= word_cnt_q + CNT_ONE;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Stage 1: packed word register and FIFO storage (data path, not reset)
    always_ff @(posedge mclk) begin
        if (state_q == S_CAPTURE) pack_p1 <= pack_nxt;
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= pack_nxt;
    end

    assign rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign rd_valid = !empty;
    assign level    = level_int;
    assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_gps_sample_capture.sv
// Randomised and directed bench for gps_sample_capture against a queue-based behavioural model.
module tb_gps_sample_capture;

    localparam int SAMPLE_W = 2;
    localparam int WORD_W   = 32;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 16;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic                mclk = 1'b0;
    logic                mclr = 1'b0;
    logic [SAMPLE_W-1:0] adc_i = '0, adc_q = '0;
    logic                fmt_sel = 0, q_en = 0, arm = 0, trig = 0, abort = 0, rd_en = 0;
    logic [CNT_W-1:0]    cap_len = '0;
    logic [WORD_W-1:0]   rd_data;
    logic                rd_valid, busy, done, overflow;
    logic [LW-1:0]       level;

    int errors = 0;
    int checks = 0;

    gps_sample_capture #(.SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .mclk(mclk), .mclr(mclr), .adc_i(adc_i), .adc_q(adc_q), .fmt_sel(fmt_sel), .q_en(q_en),
        .arm(arm), .trig(trig), .abort(abort), .cap_len(cap_len), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 armed, 2 capture, 3 done
    int                m_st = 0;
    int                m_len = 0;
    int                m_wcnt = 0;
    bit                m_qen = 0, m_fmt = 0, m_ovf = 0;
    int                slots[$];
    logic [WORD_W-1:0] fifo_q[$];
    logic [WORD_W-1:0] m_word;
    bit                m_pop, m_push;
    int                m_sz, m_spw, m_sw;

    function automatic int conv(input int x, input bit f);
        return f ? (x ^ (1 << (SAMPLE_W - 1))) : x;
    endfunction

    always @(posedge mclk or negedge mclr) begin
        if (!mclr) begin
            m_st = 0; m_len = 0; m_wcnt = 0; m_qen = 0; m_fmt = 0; m_ovf = 0;
            slots.delete();
            fifo_q.delete();
        end else begin
            m_sz   = fifo_q.size();
            m_pop  = rd_en && (m_sz > 0);
            m_push = 0;
            if (abort) begin
                m_st = 0;
                slots.delete();
            end else begin
                case (m_st)
                    0, 3: if (arm) begin
                        m_st = 1; m_len = int'(cap_len); m_qen = q_en; m_fmt = fmt_sel; m_ovf = 0;
                    end
                    1: if (trig) begin
                        m_st = (m_len == 0) ? 3 : 2;
                        m_wcnt = 0;
                        slots.delete();
                    end
                    2: begin
                        m_sw  = m_qen ? 2 * SAMPLE_W : SAMPLE_W;
                        m_spw = WORD_W / m_sw;
                        if (m_qen)
                            slots.push_back((conv(int'(adc_q), m_fmt) << SAMPLE_W) | conv(int'(adc_i), m_fmt));
                        else
                            slots.push_back(conv(int'(adc_i), m_fmt));
                        if (slots.size() == m_spw) begin
                            m_word = '0;
                            foreach (slots[k]) m_word |= WORD_W'(slots[k]) << (k * m_sw);
                            slots.delete();
                            m_push = 1;
                            m_wcnt++;
                            if (m_wcnt == m_len) m_st = 3;
                        end
                    end
                    default: m_st = 0;
                endcase
            end
            if (m_pop) void'(fifo_q.pop_front());
            if (m_push) begin
                if (m_sz < DEPTH || m_pop) fifo_q.push_back(m_word);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge mclk) begin
        if (mclr) begin
            chk("rd_data",  rd_data,  (fifo_q.size() > 0) ? fifo_q[0] : '0);
            chk("rd_valid", rd_valid, fifo_q.size() > 0);
            chk("level",    level,    fifo_q.size());
            chk("busy",     busy,     (m_st == 1) || (m_st == 2));
            chk("done",     done,     m_st == 3);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic arm_trig(input logic [CNT_W-1:0] len, input logic qe, input logic fs);
        cap_len = len; q_en = qe; fmt_sel = fs;
        arm = 1; tick(); arm = 0;
        trig = 1; tick(); trig = 0;
    endtask

    initial begin
        #22 mclr = 1;
        #1;
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        tick();

        // I/Q two's complement, two words
        adc_i = 2'b01; adc_q = 2'b10;
        arm_trig(2, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("lat_valid_early", rd_valid, 0);
            if (k == 8) begin
                chk("lat_valid", rd_valid, 1);
                chk("lat_level", level, 1);
            end
        end
        for (int k = 0; k < 8; k++) tick();
        chk("iq_done", done, 1);
        chk("iq_level", level, 2);
        chk("iq_word", rd_data, 32'h9999_9999);
        rd_en = 1; tick();
        chk("iq_word2", rd_data, 32'h9999_9999);
        tick(); rd_en = 0;
        chk("iq_drained", rd_valid, 0);

        // Offset binary input
        arm_trig(2, 1, 1);
        for (int k = 0; k < 16; k++) tick();
        chk("ob_word", rd_data, 32'h3333_3333);
        chk("ob_level", level, 2);
        rd_en = 1; tick(); tick(); rd_en = 0;

        // I-only ramp
        arm_trig(1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            adc_i = SAMPLE_W'(k % 4);
            tick();
        end
        chk("ionly_word", rd_data, 32'hE4E4_E4E4);
        chk("ionly_done", done, 1);
        rd_en = 1; tick(); rd_en = 0;

        // Overflow with no reads
        arm_trig(20, 1, 0);
        for (int k = 1; k <= 160; k++) begin
            adc_i = SAMPLE_W'($urandom); adc_q = SAMPLE_W'($urandom);
            tick();
            if (k == 128) begin
                chk("ovf_full_level", level, 16);
                chk("ovf_not_yet", overflow, 0);
            end
            if (k == 136) chk("ovf_set", overflow, 1);
        end
        chk("ovf_done", done, 1);
        chk("ovf_level", level, 16);
        rd_en = 1;
        for (int k = 0; k < 16; k++) tick();
        rd_en = 0;
        chk("ovf_drained", level, 0);
        cap_len = 3; arm = 1; tick(); arm = 0;
        chk("ovf_cleared", overflow, 0);
        abort = 1; tick(); abort = 0;

        // Abort mid-word
        adc_i = 2'b01; adc_q = 2'b10;
        arm_trig(4, 1, 0);
        for (int k = 0; k < 11; k++) tick();
        abort = 1; tick(); abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_level", level, 1);
        rd_en = 1; tick();
        chk("abort_empty_data", rd_data, 0);
        chk("abort_empty_valid", rd_valid, 0);
        tick(); rd_en = 0;
        chk("abort_empty_pop", level, 0);

        // Asynchronous reset mid-capture
        arm_trig(10, 1, 0);
        for (int k = 0; k < 40; k++) tick();
        chk("pre_rst_level", level, 5);
        #1 mclr = 0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", overflow, 0);
        @(negedge mclk); #1 mclr = 1;
        tick();

        // Push and pop on the same edge while full
        arm_trig(20, 1, 0);
        for (int k = 1; k <= 136; k++) begin
            rd_en = (k == 136);
            tick();
        end
        rd_en = 0;
        chk("full_pushpop_level", level, 16);
        chk("full_pushpop_ovf", overflow, 0);
        abort = 1; tick(); abort = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            arm     = ($urandom % 20) == 0;
            trig    = ($urandom % 6) == 0;
            abort   = ($urandom % 64) == 0;
            rd_en   = ($urandom % 3) == 0;
            cap_len = CNT_W'($urandom % 5);
            q_en    = 1'($urandom);
            fmt_sel = 1'($urandom);
            adc_i   = SAMPLE_W'($urandom);
            adc_q   = SAMPLE_W'($urandom);
            tick();
        end
        arm = 0; trig = 0; abort = 0; rd_en = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gps_sample_capture.md
Name: gps_sample_capture

Overview:
Parametrised raw-sample snapshot engine for the GPS baseband front-end. It converts the ADC I/Q samples to two's complement and packs them into words, with sample width, word width, buffer depth and I-only or I/Q mode all configurable. Capture is armed, then triggered, runs for a programmed number of words, and buffers the words in a FIFO with first-word fall-through. Management reads the FIFO over the logic analyser or wishbone glue for offline acquisition and debug of the correlator inputs.

Parameters:
SAMPLE_W, 2, bits per I or Q sample.
WORD_W, 32, packed word width. Must be divisible by 2*SAMPLE_W.
DEPTH, 16, FIFO depth in words. Must be a power of 2, at least 2.
CNT_W, 16, width of the capture-length counter.

Ports:
mclk  in  1  sample clock; the only clock.
mclr  in  1  asynchronous, active-low reset.
adc_i  in  SAMPLE_W  in-phase ADC sample.
adc_q  in  SAMPLE_W  quadrature ADC sample.
fmt_sel  in  1  0 = input is two's complement, passed through; 1 = input is offset binary, MSB inverted.
q_en  in  1  1 = pack I and Q; 0 = pack I only.
arm  in  1  single-cycle pulse that starts a new capture.
trig  in  1  capture start condition, sampled only in ARMED.
abort  in  1  single-cycle pulse that returns the block to IDLE.
cap_len  in  CNT_W  number of words to capture; latched on arm.
rd_en  in  1  FIFO pop request.
rd_data  out  WORD_W  FIFO head word; 0 when empty.
rd_valid  out  1  FIFO not empty.
level  out  $clog2(DEPTH)+1  FIFO occupancy.
busy  out  1  high in ARMED or CAPTURE.
done  out  1  high in DONE.
overflow  out  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (mclr=0, asynchronous): state IDLE, FIFO emptied, level=0, rd_valid=0, rd_data=0, busy=0, done=0, overflow=0, slot and word counters cleared.
- Slot width: 2*SAMPLE_W when q_en=1, SAMPLE_W when q_en=0.
  - q_en=1: each slot holds {q,i}, with I in the low bits.
  - Slots per word: WORD_W / slot width.
  - The first sample goes in the LSBs.
- q_en and fmt_sel are latched on arm and held constant for the capture.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: arm goes to ARMED. On that edge, cap_len/q_en/fmt_sel are latched and overflow is cleared. A trig in the same cycle as arm is ignored.
  - ARMED: trig=1 goes to CAPTURE. If the latched cap_len=0, go directly to DONE.
  - CAPTURE:
    - One sample is packed on every mclk edge, starting with the first edge in CAPTURE.
    - On the edge that fills the last slot, the word is pushed to the FIFO and the word counter increments.
    - When the word counter reaches the latched cap_len, the state goes to DONE on that same edge.
  - DONE: arm restarts the sequence (goes to ARMED with a fresh latch and overflow cleared).
  - Any state: abort goes to IDLE. Any partial word is discarded; FIFO contents and overflow are kept. abort has priority over arm.
  - arm is ignored in ARMED and CAPTURE.
- Latency, q_en=1, SAMPLE_W=2, WORD_W=32:
  - trig seen at edge T.
  - Samples are taken at edges T+1 through T+8.
  - The word is pushed at edge T+8; rd_valid=1 and level=1 after T+8.
- FIFO:
  - Pop: rd_en with rd_valid=1 advances the head on the edge.
  - rd_en while empty is ignored.
  - Push and pop in the same edge: both occur and level is unchanged. This includes the full case, where the push is accepted.
  - Push while full without a pop: the word is dropped, overflow is set, and the word still counts toward cap_len.
  - Pointers wrap modulo DEPTH.
  - level ranges from 0 to DEPTH.
- Outputs: busy and done are decoded from registered state. No combinational path from any input to any output except rd_data, which is a memory read at the registered head pointer.

Test Plan:
- Defaults, q_en=1, fmt_sel=0, adc_i=2'b01, adc_q=2'b10 constant, cap_len=2, arm then trig -> two words 0x99999999. rd_valid rises 8 cycles after trig is seen. done=1 after the 16th sample and level=2.
- Same stimulus with fmt_sel=1 -> I becomes 11 and Q becomes 00, so each word is 0x33333333.
- q_en=0, adc_i ramping 0,1,2,3 repeatedly, cap_len=1 -> one word 0xE4E4E4E4 after 16 samples.
- cap_len=20 with no reads -> level saturates at 16, overflow=1 after the 17th word, done=1 after 20 words. Reading 16 words returns the first 16 captured. A new arm clears overflow.
- abort 3 samples into the second word of a cap_len=4 capture -> state IDLE, level=1, partial word lost. Afterwards rd_en pops the first word and rd_data=0 when empty.
- mclr asserted mid-CAPTURE with level=5 -> all outputs return to reset values immediately, without waiting for a clock edge. Simultaneous push and pop at full leaves level=16 and overflow=0.
